// File: rtl/result_collector_pkg.sv
// Shared types and constants for the result collector.
// The optional RESULT_COLLECTOR_SATURATE_EN build uses SAT_POS and SAT_NEG.
package result_collector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } collector_state_t;

  localparam int unsigned NUM_ROWS_DEF = 10;
  localparam int unsigned ROW_W_DEF    = 4;
  localparam int unsigned DATA_W_DEF   = 32;

  localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG = 32'h8000_0000;

endpackage

// File: rtl/result_collector_if.sv
// Row request/result handshake between the result collector (master) and the multiplier (slave).
interface result_collector_if #(
  parameter int unsigned ROW_W  = 4,
  parameter int unsigned DATA_W = 32
);
  logic              begin_mult;
  logic [ROW_W-1:0]  row_select;
  logic              w_result_ena;
  logic [DATA_W-1:0] row_result;
  logic              overflow;
  logic              done_row;

  modport master (
    output begin_mult, row_select,
    input  w_result_ena, row_result, overflow, done_row
  );

  modport slave (
    input  begin_mult, row_select,
    output w_result_ena, row_result, overflow, done_row
  );
endinterface

// File: rtl/result_collector_argmax_tracker.sv
// Running signed argmax: load takes the value unconditionally, update only when strictly greater.
module argmax_tracker #(
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load,
  input  logic              update,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic [DATA_W-1:0] in_value,
  output logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] value
);

  logic take;

  // Ties keep the earlier (lower) index because the compare is strict.
  assign take = load || (update && ($signed(in_value) > $signed(value)));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idx   <= '0;
      value <= '0;
    end else if (take) begin
      idx   <= in_idx;
      value <= in_value;
    end
  end

endmodule

// File: rtl/result_collector.sv
// Sequences multiplier rows, stores per-row scores and reports the signed argmax.
// Define RESULT_COLLECTOR_SATURATE_EN to clamp overflowed results instead of storing them wrapped.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int unsigned NUM_ROWS = NUM_ROWS_DEF,
  parameter int unsigned ROW_W    = ROW_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  result_collector_if.master  mif,
  input  logic [ROW_W-1:0]    score_sel,
  output logic [DATA_W-1:0]   score_out,
  output logic                busy,
  output logic                classify_done,
  output logic [ROW_W-1:0]    digit,
  output logic [DATA_W-1:0]   max_value,
  output logic                any_overflow,
  output logic                protocol_err
);

  collector_state_t  state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              any_ovf_d;
  logic              perr_d;
  logic              capture;
  logic              last_row;
  logic [DATA_W-1:0] cap_value;
  logic [DATA_W-1:0] score_q [NUM_ROWS];

  assign last_row       = (row_q == ROW_W'(NUM_ROWS - 1));
  assign mif.row_select = row_q;

`ifdef RESULT_COLLECTOR_SATURATE_EN
  // MSB set on an overflowed result means the true value was positive.
  assign cap_value = !mif.overflow ? mif.row_result
                   : (mif.row_result[DATA_W-1] ? DATA_W'(SAT_POS) : DATA_W'(SAT_NEG));
`else
  assign cap_value = mif.row_result;
`endif

  // Next-state, row counter and sticky flag logic.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    any_ovf_d = any_overflow;
    perr_d    = protocol_err;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ISSUE;
          row_d     = '0;
          any_ovf_d = 1'b0;
          perr_d    = 1'b0;
        end else if (mif.w_result_ena) begin
          perr_d = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        if (mif.w_result_ena) perr_d = 1'b1;
      end
      WAIT: begin
        if (mif.w_result_ena) begin
          capture   = 1'b1;
          any_ovf_d = any_overflow | mif.overflow;
          if (!mif.done_row) perr_d = 1'b1;
          if (last_row) begin
            state_d = DONE;
          end else begin
            row_d   = row_q + ROW_W'(1);
            state_d = ISSUE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (mif.w_result_ena) perr_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, derived from the next state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      row_q          <= '0;
      mif.begin_mult <= 1'b0;
      busy           <= 1'b0;
      classify_done  <= 1'b0;
      any_overflow   <= 1'b0;
      protocol_err   <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      mif.begin_mult <= (state_d == ISSUE);
      busy           <= (state_d != IDLE);
      classify_done  <= (state_d == DONE);
      any_overflow   <= any_ovf_d;
      protocol_err   <= perr_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(NUM_ROWS); i++) score_q[i] <= '0;
    end else if (capture) begin
      score_q[row_q] <= cap_value;
    end
  end

  assign score_out = (score_sel < ROW_W'(NUM_ROWS)) ? score_q[score_sel] : '0;

  argmax_tracker #(
    .IDX_W  (ROW_W),
    .DATA_W (DATA_W)
  ) u_argmax (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (capture && (row_q == '0)),
    .update   (capture && (row_q != '0)),
    .in_idx   (row_q),
    .in_value (cap_value),
    .idx      (digit),
    .value    (max_value)
  );

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: the bench plays the multiplier and checks sequencing,
// argmax, overflow, protocol error and mid-run reset behaviour.
module tb_result_collector;
  import result_collector_pkg::*;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic [3:0]  score_sel;
  logic [31:0] score_out;
  logic        busy;
  logic        classify_done;
  logic [3:0]  digit;
  logic [31:0] max_value;
  logic        any_overflow;
  logic        protocol_err;

  int checks;
  int failures;

  logic [31:0] sc [10];
  logic        ov [10];

  result_collector_if #(.ROW_W(4), .DATA_W(32)) mif ();

  result_collector dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .start         (start),
    .mif           (mif),
    .score_sel     (score_sel),
    .score_out     (score_out),
    .busy          (busy),
    .classify_done (classify_done),
    .digit         (digit),
    .max_value     (max_value),
    .any_overflow  (any_overflow),
    .protocol_err  (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic wait_begin(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mif.begin_mult === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_bm"},    32'(mif.begin_mult), 32'd0);
    check({tag, "_rsel"},  32'(mif.row_select), 32'd0);
    check({tag, "_done"},  32'(classify_done), 32'd0);
    check({tag, "_digit"}, 32'(digit), 32'd0);
    check({tag, "_max"},   max_value, 32'd0);
    check({tag, "_ovf"},   32'(any_overflow), 32'd0);
    check({tag, "_perr"},  32'(protocol_err), 32'd0);
    check({tag, "_score"}, score_out, 32'd0);
  endtask

  // One classification; mid_start/abort/nodone select a row for that disturbance (-1 = none).
  task automatic run(input string tag, input int mid_start_row, input int abort_row,
                     input int nodone_row, input logic [3:0] exp_digit,
                     input logic [31:0] exp_max, input logic exp_ovf, input logic exp_perr);
    bit ok;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    check({tag, "_perr_clr"}, 32'(protocol_err), 32'd0);
    for (int r = 0; r < 10; r++) begin
      wait_begin(ok);
      check({tag, "_begin_seen"}, 32'(ok), 32'd1);
      if (!ok) return;
      check({tag, "_row_sel"}, 32'(mif.row_select), 32'(r));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      check({tag, "_bm_pulse"}, 32'(mif.begin_mult), 32'd0);
      if (r == abort_row) begin
        n_rst = 1'b0;
        #1;
        check_all_zero({tag, "_abort"});
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        return;
      end
      if (r == mid_start_row) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_row_hold"}, 32'(mif.row_select), 32'(r));
      mif.row_result   = sc[r];
      mif.overflow     = ov[r];
      mif.done_row     = (r != nodone_row);
      mif.w_result_ena = 1'b1;
      @(negedge clk);
      mif.w_result_ena = 1'b0;
      mif.done_row     = 1'b0;
      mif.overflow     = 1'b0;
      mif.row_result   = '0;
    end
    check({tag, "_cdone"}, 32'(classify_done), 32'd1);
    check({tag, "_digit"}, 32'(digit), 32'(exp_digit));
    check({tag, "_max"}, max_value, exp_max);
    check({tag, "_any_ovf"}, 32'(any_overflow), 32'(exp_ovf));
    check({tag, "_perr"}, 32'(protocol_err), 32'(exp_perr));
    @(negedge clk);
    check({tag, "_cdone_pulse"}, 32'(classify_done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    n_rst    = 1'b0;
    start    = 1'b0;
    score_sel = 4'd0;
    mif.w_result_ena = 1'b0;
    mif.row_result   = '0;
    mif.overflow     = 1'b0;
    mif.done_row     = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset");

    // Mixed scores with a tie at 100: lower index wins.
    sc = '{32'd5, -32'sd3, 32'd100, 32'd7, 32'd100, 32'd0, 32'd0, 32'd0, 32'd0, -32'sd1};
    ov = '{default: 1'b0};
    run("mixed", -1, -1, -1, 4'd2, 32'd100, 1'b0, 1'b0);
    score_sel = 4'd2; #1 check("mixed_score2", score_out, 32'd100);
    score_sel = 4'd9; #1 check("mixed_score9", score_out, 32'hFFFF_FFFF);
    score_sel = 4'd12; #1 check("sel_oob", score_out, 32'd0);

    // All negative with a stray start mid-run and one result missing done_row.
    for (int r = 0; r < 10; r++) sc[r] = 32'(-50 + r);
    run("neg", 3, -1, 5, 4'd9, 32'hFFFF_FFD7, 1'b0, 1'b1);
    score_sel = 4'd0; #1 check("neg_score0", score_out, 32'hFFFF_FFCE);

    // Overflow on row 4.
    for (int r = 0; r < 10; r++) begin
      sc[r] = 32'(10 * r);
      ov[r] = 1'b0;
    end
    sc[4] = 32'h8000_0001;
    ov[4] = 1'b1;
`ifdef RESULT_COLLECTOR_SATURATE_EN
    run("ovf", -1, -1, -1, 4'd4, 32'h7FFF_FFFF, 1'b1, 1'b0);
    score_sel = 4'd4; #1 check("ovf_score4", score_out, 32'h7FFF_FFFF);
`else
    run("ovf", -1, -1, -1, 4'd9, 32'd90, 1'b1, 1'b0);
    score_sel = 4'd4; #1 check("ovf_score4", score_out, 32'h8000_0001);
`endif

    // Stray result strobe while idle.
    @(negedge clk);
    mif.w_result_ena = 1'b1;
    @(negedge clk);
    mif.w_result_ena = 1'b0;
    check("idle_perr", 32'(protocol_err), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    sc = '{32'd5, -32'sd3, 32'd100, 32'd7, 32'd100, 32'd0, 32'd0, 32'd0, 32'd0, -32'sd1};
    ov = '{default: 1'b0};
    run("perr_clear", -1, -1, -1, 4'd2, 32'd100, 1'b0, 1'b0);

    // Reset in WAIT of row 6, then a clean restart from row 0.
    run("abort", -1, 6, -1, 4'd0, 32'd0, 1'b0, 1'b0);
    check_all_zero("post_abort");
    for (int r = 0; r < 10; r++) sc[r] = 32'(-50 + r);
    run("restart", -1, -1, -1, 4'd9, 32'hFFFF_FFD7, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
